vbit_fifo: RTL and testbench
============================

VBIT_FIFO -- requirements
Module: vbit_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the entry count; it SHALL be a power of 2 and at least 2.
REQ-003 Port clk SHALL be an input, 1 bit wide: the clock; all state changes on its rising edge.
REQ-004 Port rstn SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-005 Port vbit_i SHALL be an input, 1 bit wide: upstream valid bit from the pipeline register stage, with no backpressure.
REQ-006 Port data_i SHALL be an input, WIDTH bits wide: upstream data, qualified by vbit_i.
REQ-007 Port vld_o SHALL be an output, 1 bit wide: a head word is available.
REQ-008 Port data_o SHALL be an output, WIDTH bits wide: the head word, valid only while vld_o=1.
REQ-009 Port rdy_i SHALL be an input, 1 bit wide: the consumer accepts the head word.
REQ-010 Port count_o SHALL be an output, $clog2(DEPTH)+1 bits wide: current occupancy.
REQ-011 Port full_o SHALL be an output, 1 bit wide: asserted when count_o==DEPTH.
REQ-012 Port ovf_o SHALL be an output, 1 bit wide: sticky flag meaning a word has been dropped.
REQ-013 Port ovf_clr_i SHALL be an input, 1 bit wide: a one-cycle pulse that clears the overflow state.

Function
REQ-014 A push SHALL occur when vbit_i=1 and either full_o=0 or a pop occurs in the same cycle.
REQ-015 A pop SHALL occur when vld_o=1 and rdy_i=1; the consumer SHALL see data_o in show-ahead form, before the pop.
REQ-016 vld_o SHALL equal (count_o!=0) and be driven from registered state only, with no combinational path from vbit_i or data_i.
REQ-017 A pushed word SHALL reach data_o with 1-cycle latency when the FIFO is empty; there SHALL be no same-cycle bypass.
REQ-018 Words SHALL leave in strict push order; the read and write pointers SHALL wrap modulo DEPTH.
REQ-019 With a push and a pop in the same cycle, count_o SHALL be unchanged, including at full and at count 1.
REQ-020 A pop when empty SHALL be impossible because vld_o=0; rdy_i SHALL be ignored while vld_o=0.
REQ-021 With vbit_i=1, full_o=1 and no pop, the word SHALL be dropped, the storage left unchanged, and ovf_o set on the next edge.
REQ-022 ovf_o SHALL stay set until ovf_clr_i=1; if a clear and a new drop occur in the same cycle, set SHALL win.
REQ-023 vbit_i=0 SHALL mean data_i is ignored entirely.

Reset
REQ-024 rstn=0 SHALL asynchronously force vld_o=0, count_o=0, full_o=0, ovf_o=0, both pointers to 0, and data_o to 0.
REQ-025 A reset asserted mid-operation SHALL discard all buffered words; the storage array need not be reset, but data_o SHALL read 0 while empty.
REQ-026 After rstn is released, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-027 With macro VBIT_FIFO_OVF_CNT_EN defined, the block SHALL add output ovf_cnt_o, 8 bits wide: a count of dropped words that saturates at 255, is cleared by ovf_clr_i (increment wins on the same cycle, giving 1), and is reset to 0.
REQ-028 With VBIT_FIFO_OVF_CNT_EN undefined, port ovf_cnt_o and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package vbit_fifo_pkg SHALL hold the default WIDTH (20), the default DEPTH (8) and the overflow-counter width (8).
REQ-030 Sub-module vbit_fifo_mem SHALL hold the DEPTH x WIDTH register array, with one synchronous write port and one asynchronous read port; the pointer, count and flag logic SHALL stay in vbit_fifo.

Verification
REQ-031 Scenario: reset, then a single vbit_i=1 with data_i=0x00ABC and rdy_i=0 -> vld_o=1 on the next cycle, data_o=0x00ABC, count_o=1.
REQ-032 Scenario: push 0x1..0x8 on consecutive cycles with rdy_i=0 -> full_o=1, count_o=8; then rdy_i=1 -> data_o pops 0x1..0x8 in order.
REQ-033 Scenario: FIFO full, then vbit_i=1 with data 0x9 and rdy_i=1 in the same cycle -> count_o stays 8, no overflow, and 0x9 is output eighth after the current head.
REQ-034 Scenario: FIFO full, rdy_i=0, three pushes -> ovf_o=1, contents unchanged, ovf_cnt_o=3 (macro defined); then an ovf_clr_i pulse -> ovf_o=0 and ovf_cnt_o=0.
REQ-035 Scenario: count_o=5, then rstn pulsed low mid-stream -> vld_o, count_o and ovf_o read 0 immediately, before the next clock edge.
REQ-036 Scenario: random vbit_i and rdy_i over 10k cycles, checked against a scoreboard queue -> no reordering or loss except counted drops.

Source files
------------

// File: rtl/vbit_fifo_pkg.sv
// Shared defaults for the valid-bit FIFO: data width, depth and overflow-counter width.
package vbit_fifo_pkg;

  localparam int unsigned VBIT_FIFO_WIDTH = 20;
  localparam int unsigned VBIT_FIFO_DEPTH = 8;
  localparam int unsigned OVF_CNT_W       = 8;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vbit_fifo_mem.sv
// DEPTH x WIDTH storage for vbit_fifo: one synchronous write port, one asynchronous read port.
module vbit_fifo_mem
  import vbit_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = VBIT_FIFO_WIDTH,
  parameter int unsigned DEPTH = VBIT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [WIDTH-1:0]          o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are not reset; the top masks the read data while empty.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vbit_fifo.sv
// Show-ahead FIFO behind a valid-bit pipeline stage; drops words when full and flags overflow.
// Optional VBIT_FIFO_OVF_CNT_EN adds a saturating dropped-word counter on ovf_cnt_o.
module vbit_fifo
  import vbit_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = VBIT_FIFO_WIDTH,
  parameter int unsigned DEPTH = VBIT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vbit_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     vld_o,
  output logic [WIDTH-1:0]         data_o,
  input  logic                     rdy_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     ovf_o,
`ifdef VBIT_FIFO_OVF_CNT_EN
  output logic [OVF_CNT_W-1:0]     ovf_cnt_o,
`endif
  input  logic                     ovf_clr_i
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_vld;
  logic             r_full;
  logic             r_ovf;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_rdata;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop  = r_vld & rdy_i;
  assign w_push = vbit_i & (~r_full | w_pop);
  assign w_drop = vbit_i & r_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers, occupancy and status flags; vld/full are registered from next-count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_vld   <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Sticky overflow: a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef VBIT_FIFO_OVF_CNT_EN
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Saturating drop counter; drop together with clear restarts the count at 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr_i) begin
        r_ovf_cnt <= OVF_CNT_W'(1);
      end else if (r_ovf_cnt != OVF_CNT_MAX) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
      end
    end else if (ovf_clr_i) begin
      r_ovf_cnt <= '0;
    end
  end

  assign ovf_cnt_o = r_ovf_cnt;
`endif

  vbit_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Head word is masked to zero while empty so stale storage never shows.
  assign data_o  = r_vld ? w_rdata : '0;
  assign vld_o   = r_vld;
  assign count_o = r_count;
  assign full_o  = r_full;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_vbit_fifo.sv
// Directed and scoreboard-checked bench for vbit_fifo (honours VBIT_FIFO_OVF_CNT_EN).
module tb_vbit_fifo;

  localparam int unsigned W = 20;
  localparam int unsigned D = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          vbit_i;
  logic [W-1:0]  data_i;
  logic          vld_o;
  logic [W-1:0]  data_o;
  logic          rdy_i;
  logic [3:0]    count_o;
  logic          full_o;
  logic          ovf_o;
  logic          ovf_clr_i;
`ifdef VBIT_FIFO_OVF_CNT_EN
  logic [7:0]    ovf_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  vbit_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vbit_i    (vbit_i),
    .data_i    (data_i),
    .vld_o     (vld_o),
    .data_o    (data_o),
    .rdy_i     (rdy_i),
    .count_o   (count_o),
    .full_o    (full_o),
    .ovf_o     (ovf_o),
`ifdef VBIT_FIFO_OVF_CNT_EN
    .ovf_cnt_o (ovf_cnt_o),
`endif
    .ovf_clr_i (ovf_clr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    vbit_i = 1'b0; rdy_i = 1'b0; ovf_clr_i = 1'b0; data_i = '0;
  endtask

  // Inputs change just after negedge; outputs are observed at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int i = 1; i <= int'(D); i++) begin
      vbit_i = 1'b1; rdy_i = 1'b0; data_i = base + W'(i);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (vld_o !== 1'b0)   begin n_err++; $display("FAIL reset_vld: got %b want 0", vld_o); end
    n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_vec++; if (full_o !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_vec++; if (ovf_o !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    n_vec++; if (data_o !== 20'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_o); end
`ifdef VBIT_FIFO_OVF_CNT_EN
    n_vec++; if (ovf_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_ovf_cnt: got %0d want 0", ovf_cnt_o); end
`endif
  endtask

  task automatic test_single();
    vbit_i = 1'b1; data_i = 20'h00ABC; rdy_i = 1'b0;
    #1;
    n_vec++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got vld %b want 0", vld_o); end
    step(); idle();
    n_vec++; if (vld_o !== 1'b1)      begin n_err++; $display("FAIL single_vld: got %b want 1", vld_o); end
    n_vec++; if (data_o !== 20'h00ABC) begin n_err++; $display("FAIL single_data: got %h want 00abc", data_o); end
    n_vec++; if (count_o !== 4'd1)    begin n_err++; $display("FAIL single_count: got %0d want 1", count_o); end
    rdy_i = 1'b1; step(); idle();
    n_vec++; if (vld_o !== 1'b0 || count_o !== 4'd0 || data_o !== 20'h0)
      begin n_err++; $display("FAIL single_pop: got vld %b cnt %0d data %h want 0 0 0", vld_o, count_o, data_o); end
    rdy_i = 1'b1; step(); idle();
    n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL empty_rdy_ignored: got cnt %0d want 0", count_o); end
  endtask

  task automatic test_fill_drain();
    fill(20'h0);
    n_vec++; if (full_o !== 1'b1)  begin n_err++; $display("FAIL fill_full: got %b want 1", full_o); end
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count_o); end
    for (int i = 1; i <= int'(D); i++) begin
      n_vec++; if (data_o !== W'(i)) begin n_err++; $display("FAIL drain_order: got %h want %h", data_o, W'(i)); end
      rdy_i = 1'b1; step();
    end
    idle();
    n_vec++; if (count_o !== 4'd0 || full_o !== 1'b0 || vld_o !== 1'b0)
      begin n_err++; $display("FAIL drain_empty: got cnt %0d full %b vld %b want 0 0 0", count_o, full_o, vld_o); end
  endtask

  task automatic test_full_push_pop();
    fill(20'h0);
    vbit_i = 1'b1; data_i = 20'h9; rdy_i = 1'b1;
    step(); idle();
    n_vec++; if (count_o !== 4'd8 || full_o !== 1'b1)
      begin n_err++; $display("FAIL fullpp_count: got cnt %0d full %b want 8 1", count_o, full_o); end
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf: got %b want 0", ovf_o); end
    for (int i = 2; i <= 9; i++) begin
      n_vec++; if (data_o !== W'(i)) begin n_err++; $display("FAIL fullpp_order: got %h want %h", data_o, W'(i)); end
      rdy_i = 1'b1; step();
    end
    idle();
    n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL fullpp_empty: got %0d want 0", count_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    fill(20'h100);
    for (int i = 0; i < 3; i++) begin
      vbit_i = 1'b1; data_i = 20'hFFFFF; rdy_i = 1'b0; step();
    end
    idle();
    n_vec++; if (ovf_o !== 1'b1)   begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", count_o); end
`ifdef VBIT_FIFO_OVF_CNT_EN
    n_vec++; if (ovf_cnt_o !== 8'd3) begin n_err++; $display("FAIL ovf_cnt3: got %0d want 3", ovf_cnt_o); end
`endif
    ovf_clr_i = 1'b1; step(); idle();
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", ovf_o); end
`ifdef VBIT_FIFO_OVF_CNT_EN
    n_vec++; if (ovf_cnt_o !== 8'd0) begin n_err++; $display("FAIL ovf_cnt_clr: got %0d want 0", ovf_cnt_o); end
`endif
    vbit_i = 1'b1; data_i = 20'hEEEEE; ovf_clr_i = 1'b1; step(); idle();
    n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", ovf_o); end
`ifdef VBIT_FIFO_OVF_CNT_EN
    n_vec++; if (ovf_cnt_o !== 8'd1) begin n_err++; $display("FAIL ovf_cnt_set_wins: got %0d want 1", ovf_cnt_o); end
`endif
    ovf_clr_i = 1'b1; step(); idle();
    for (int i = 1; i <= int'(D); i++) begin
      n_vec++; if (data_o !== 20'h100 + W'(i))
        begin n_err++; $display("FAIL ovf_contents: got %h want %h", data_o, 20'h100 + W'(i)); end
      rdy_i = 1'b1; step();
    end
    idle();
  endtask

  task automatic test_count1_push_pop();
    vbit_i = 1'b1; data_i = 20'h55; step();
    vbit_i = 1'b1; data_i = 20'h66; rdy_i = 1'b1;
    #1;
    n_vec++; if (data_o !== 20'h55) begin n_err++; $display("FAIL c1_showahead: got %h want 55", data_o); end
    step(); idle();
    n_vec++; if (count_o !== 4'd1 || data_o !== 20'h66)
      begin n_err++; $display("FAIL c1_pushpop: got cnt %0d data %h want 1 66", count_o, data_o); end
    rdy_i = 1'b1; step(); idle();
  endtask

  task automatic test_mid_reset();
    fill(20'h200);
    vbit_i = 1'b1; data_i = 20'h3; step();
    rdy_i = 1'b1; vbit_i = 1'b0; repeat (3) step();
    idle();
    n_vec++; if (count_o !== 4'd5 || ovf_o !== 1'b1)
      begin n_err++; $display("FAIL mr_pre: got cnt %0d ovf %b want 5 1", count_o, ovf_o); end
    #1 rstn = 1'b0;
    #1;
    n_vec++; if (vld_o !== 1'b0 || count_o !== 4'd0 || ovf_o !== 1'b0 || data_o !== 20'h0 || full_o !== 1'b0)
      begin n_err++; $display("FAIL mr_async: got vld %b cnt %0d ovf %b data %h want 0 0 0 0", vld_o, count_o, ovf_o, data_o); end
    @(negedge clk);
    rstn = 1'b1; vbit_i = 1'b1; data_i = 20'h77;
    step(); idle();
    n_vec++; if (count_o !== 4'd1 || vld_o !== 1'b1 || data_o !== 20'h77)
      begin n_err++; $display("FAIL mr_first_push: got cnt %0d vld %b data %h want 1 1 77", count_o, vld_o, data_o); end
    rdy_i = 1'b1; step(); idle();
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    int drops = 0;
    int rnd_err = 0;
    bit pop, push;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      n_vec++;
      if (vld_o !== (q.size() != 0) || count_o !== 4'(q.size()) || full_o !== (q.size() == int'(D)) ||
          ovf_o !== (drops != 0) || data_o !== ((q.size() != 0) ? q[0] : W'(0))) begin
        n_err++; rnd_err++;
        if (rnd_err <= 5)
          $display("FAIL random_c%0d: got vld %b cnt %0d ovf %b data %h want cnt %0d drops %0d head %h",
                   c, vld_o, count_o, ovf_o, data_o, q.size(), drops, (q.size() != 0) ? q[0] : W'(0));
      end
      vbit_i = ($urandom_range(0, 99) < 60);
      rdy_i  = ($urandom_range(0, 99) < (((c / 1000) % 2 == 1) ? 30 : 75));
      data_i = W'($urandom);
      pop  = (q.size() != 0) && rdy_i;
      push = vbit_i && ((q.size() < int'(D)) || pop);
      step();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(data_i);
      else if (vbit_i) drops++;
    end
    idle();
`ifdef VBIT_FIFO_OVF_CNT_EN
    n_vec++; if (ovf_cnt_o !== 8'((drops > 255) ? 255 : drops))
      begin n_err++; $display("FAIL random_ovf_cnt: got %0d want %0d", ovf_cnt_o, (drops > 255) ? 255 : drops); end
`endif
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_count1_push_pop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
